// File: rtl/filtro_mac.sv
// Sequencer and single-multiplier MAC for the three-tap filter delay line.
// Each accepted sample is loaded, shifted in, multiply-accumulated over three cycles, then saturated.
module filtro_mac #(
   parameter int N    = 25,
   parameter int FRAC = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2*N-1:0]   x_in,
   input  logic [2*N-1:0]   b0,
   input  logic [2*N-1:0]   b1,
   input  logic [2*N-1:0]   b2,
   input  logic [2*N-1:0]   fk,
   input  logic [2*N-1:0]   fk_1,
   input  logic [2*N-1:0]   fk_2,
   output logic [2*N-1:0]   sample_o,
   output logic             shift,
   output logic [2*N-1:0]   y,
   output logic             valid,
   output logic             sat,
   output logic             busy
);

   // state | meaning
   // IDLE  | waiting for start, sample_o holds last sample
   // LOAD  | sample_o settling before the shift strobe
   // SHIFT | strobe high, delay line captures sample_o
   // MAC1  | acc = b0*fk already done, adding b1*fk_1
   // MAC2  | adding b2*fk_2
   // OUT   | saturate and publish y with valid
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, MAC1, MAC2, OUT} state_t;

   localparam int W  = 2 * N;
   localparam int PW = 2 * W;
   localparam int AW = 2 * W + 2;

   localparam logic signed [AW-1:0] YMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] YMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

   state_t state;

   logic [W-1:0]            mul_a;
   logic [W-1:0]            mul_b;
   logic signed [PW-1:0]    a_ext;
   logic signed [PW-1:0]    b_ext;
   logic signed [PW-1:0]    prod;
   logic signed [AW-1:0]    prod_ext;
   logic signed [AW-1:0]    acc;
   logic signed [AW-1:0]    acc_sh;

   // One shared multiplier: operand pair selected by the current MAC phase.
   always_comb begin
      mul_a = b0;
      mul_b = fk;
      case (state)
         MAC1: begin
            mul_a = b1;
            mul_b = fk_1;
         end
         MAC2: begin
            mul_a = b2;
            mul_b = fk_2;
         end
         default: ;
      endcase
   end

   assign a_ext    = {{W{mul_a[W-1]}}, mul_a};
   assign b_ext    = {{W{mul_b[W-1]}}, mul_b};
   assign prod     = a_ext * b_ext;
   assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
   assign acc_sh   = acc >>> FRAC;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sample_o <= '0;
         shift    <= 1'b0;
         y        <= '0;
         valid    <= 1'b0;
         sat      <= 1'b0;
         busy     <= 1'b0;
         acc      <= '0;
      end else begin
         valid <= 1'b0;
         sat   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sample_o <= x_in;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               shift <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               shift <= 1'b0;
               acc   <= prod_ext;
               state <= MAC1;
            end
            MAC1: begin
               acc   <= acc + prod_ext;
               state <= MAC2;
            end
            MAC2: begin
               acc   <= acc + prod_ext;
               state <= OUT;
            end
            OUT: begin
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
               if (acc_sh > YMAX) begin
                  y   <= YMAX[W-1:0];
                  sat <= 1'b1;
               end else if (acc_sh < YMIN) begin
                  y   <= YMIN[W-1:0];
                  sat <= 1'b1;
               end else begin
                  y   <= acc_sh[W-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
